hamming_encoder_tx: RTL and testbench

Transmit-side counterpart of the Li-Fi Hamming(7,4) decoder. It accepts 4-bit messages over a valid/ready handshake and buffers them in a small FIFO. Each message is encoded into a 7-bit Hamming codeword using the same bit mapping the decoder expects. Each codeword is then serialized as a framed, fixed-rate bit stream on tx_bit, which drives the LED modulator.

---
 rtl/hamming_encoder_tx_pkg.sv | 42 ++++
 rtl/hamming_tx_fifo.sv | 64 ++++++
 rtl/hamming_encoder_tx.sv | 142 ++++++++++++++
 tb/tb_hamming_encoder_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_encoder_tx_pkg.sv
// Shared Hamming(7,4) definitions for the Li-Fi transmit path: codeword bit map,
// frame constants and the parity encoder used by both encoder and decoder.
package hamming_encoder_tx_pkg;

  localparam int unsigned MSG_W = 4;
  localparam int unsigned CW_W  = 7;

  // Codeword bit positions, codeword[6:0] = {d3,d2,d1,p4,d0,p2,p1}
  localparam int unsigned CW_P1 = 0;
  localparam int unsigned CW_P2 = 1;
  localparam int unsigned CW_D0 = 2;
  localparam int unsigned CW_P4 = 3;
  localparam int unsigned CW_D1 = 4;
  localparam int unsigned CW_D2 = 5;
  localparam int unsigned CW_D3 = 6;

  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned FRAME_BITS = 9;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic logic [CW_W-1:0] hamming_encode(input logic [MSG_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw        = '0;
    cw[CW_D0] = d[0];
    cw[CW_D1] = d[1];
    cw[CW_D2] = d[2];
    cw[CW_D3] = d[3];
    cw[CW_P1] = d[0] ^ d[1] ^ d[3];
    cw[CW_P2] = d[0] ^ d[2] ^ d[3];
    cw[CW_P4] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_tx_fifo.sv
// Synchronous message FIFO with push/pop, full/empty flags and occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module hamming_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally since the depth is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hamming_encoder_tx.sv
// Li-Fi transmit path: buffers 4-bit messages, Hamming(7,4)-encodes each one and
// serializes it as a start/7-data/stop frame on tx_bit (idle high).
module hamming_encoder_tx
  import hamming_encoder_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [MSG_W-1:0] message,
  output logic             ready,
  output logic [CW_W-1:0]  codeword,
  output logic             codeword_valid,
  output logic             tx_bit,
  output logic             tx_busy
);

  localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_e        state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [BIT_W-1:0] bit_q;
  logic [CW_W-1:0]  shift_q;
  logic [CW_W-1:0]  codeword_q;
  logic             cw_valid_q;
  logic             tx_bit_q;
  logic             tx_busy_q;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [MSG_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             bit_done;
  logic [CW_W-1:0]  head_cw;

  // ready is forced high while reset is held; the FIFO ignores pushes then
  assign ready     = !reset || (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push = valid && !fifo_full;
  assign bit_done  = (cyc_q == CYC_LAST);
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
  assign head_cw   = hamming_encode(fifo_head);

  hamming_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (MSG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (message),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame sequencer; a pop always starts a new frame, whether from IDLE or end of STOP
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      codeword_q <= '0;
      cw_valid_q <= 1'b0;
      tx_bit_q   <= STOP_BIT;
      tx_busy_q  <= 1'b0;
    end else begin
      cw_valid_q <= 1'b0;
      if (fifo_pop) begin
        state_q    <= ST_START;
        cyc_q      <= '0;
        bit_q      <= '0;
        shift_q    <= head_cw;
        codeword_q <= head_cw;
        cw_valid_q <= 1'b1;
        tx_bit_q   <= START_BIT;
        tx_busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            tx_bit_q  <= STOP_BIT;
            tx_busy_q <= 1'b0;
          end
          ST_START: begin
            if (bit_done) begin
              state_q  <= ST_DATA;
              cyc_q    <= '0;
              bit_q    <= '0;
              tx_bit_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end else begin
              cyc_q <= cyc_q + CYC_W'(1);
            end
          end
          ST_DATA: begin
            if (bit_done) begin
              cyc_q <= '0;
              if (bit_q == BIT_LAST) begin
                state_q  <= ST_STOP;
                tx_bit_q <= STOP_BIT;
              end else begin
                bit_q    <= bit_q + BIT_W'(1);
                tx_bit_q <= shift_q[0];
                shift_q  <= shift_q >> 1;
              end
            end else begin
              cyc_q <= cyc_q + CYC_W'(1);
            end
          end
          ST_STOP: begin
            if (bit_done) begin
              state_q   <= ST_IDLE;
              cyc_q     <= '0;
              tx_busy_q <= 1'b0;
            end else begin
              cyc_q <= cyc_q + CYC_W'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            tx_bit_q  <= STOP_BIT;
            tx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign codeword       = codeword_q;
  assign codeword_valid = cw_valid_q;
  assign tx_bit         = tx_bit_q;
  assign tx_busy        = tx_busy_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Directed bench for hamming_encoder_tx: encode table, framing, FIFO overflow,
// loopback through a decoder model, mid-frame reset and push-on-pop.
module tb_hamming_encoder_tx;

  localparam int unsigned BC    = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [3:0] message;
  logic       ready;
  logic [6:0] codeword;
  logic       codeword_valid;
  logic       tx_bit;
  logic       tx_busy;

  int n_pass  = 0;
  int n_total = 0;

  // Hand-computed codewords {d3,d2,d1,p4,d0,p2,p1} for messages 0..15
  logic [6:0] cw_tab [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                              7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

  hamming_encoder_tx #(
    .BIT_CYCLES (BC),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .valid          (valid),
    .message        (message),
    .ready          (ready),
    .codeword       (codeword),
    .codeword_valid (codeword_valid),
    .tx_bit         (tx_bit),
    .tx_busy        (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] m);
    valid   = 1'b1;
    message = m;
    step();
    valid   = 1'b0;
  endtask

  task automatic wait_cv(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (codeword_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called right after the load edge; samples each bit mid-period and
  // returns aligned to the first edge after the frame.
  task automatic read_frame(output logic [8:0] bits);
    repeat (BC / 2) step();
    bits[0] = tx_bit;
    for (int i = 1; i < 9; i++) begin
      repeat (BC) step();
      bits[i] = tx_bit;
    end
    repeat (BC - BC / 2) step();
  endtask

  function automatic logic [8:0] frame_of(input logic [6:0] cw);
    return {1'b1, cw, 1'b0};
  endfunction

  // Syndrome decoder: positions 1..7 map to codeword[0..6]
  function automatic logic [3:0] dec(input logic [8:0] f);
    logic [6:0] c;
    logic [2:0] s;
    int         idx;
    c = f[7:1];
    s = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
    if (s != 3'd0) begin
      idx    = int'(s) - 1;
      c[idx] = ~c[idx];
    end
    return {c[6], c[5], c[4], c[2]};
  endfunction

  initial begin
    bit         seen;
    logic [8:0] fb;
    logic [8:0] fb1;
    logic [5:0] rdy;
    logic [3:0] m3 [6];
    int         accepted;
    int         busy_cnt;
    bit         idle_ok;
    int         flip_idx;

    reset   = 1'b0;
    valid   = 1'b0;
    message = 4'h0;
    m3      = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};

    // --- Test 1: reset state and single frame for 4'b1011
    repeat (3) step();
    chk("ready_in_reset", 32'(ready), 32'd1);
    reset = 1'b1;
    chk("rst_tx_bit", 32'(tx_bit), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_codeword", 32'(codeword), 32'd0);
    chk("rst_cw_valid", 32'(codeword_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    push(4'b1011);
    chk("t1_cv_at_push", 32'(codeword_valid), 32'd0);
    chk("t1_busy_at_push", 32'(tx_busy), 32'd0);
    step();
    chk("t1_cv_pulse", 32'(codeword_valid), 32'd1);
    chk("t1_codeword", 32'(codeword), 32'h55);
    chk("t1_start_bit", 32'(tx_bit), 32'd0);
    busy_cnt = 0;
    idle_ok  = 1'b1;
    fb       = '0;
    for (int j = 0; j < 40; j++) begin
      if ((j % BC) == BC / 2 && j < 36) fb[j / BC] = tx_bit;
      if (tx_busy === 1'b1) busy_cnt++;
      if (j >= 36 && tx_bit !== 1'b1) idle_ok = 1'b0;
      if (j == 1) chk("t1_cv_one_cycle", 32'(codeword_valid), 32'd0);
      step();
    end
    chk("t1_frame_bits", 32'(fb), 32'h1AA);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd36);
    chk("t1_idle_high", 32'(idle_ok), 32'd1);

    // --- Test 2: encode table, back-to-back frames
    push(4'h0);
    wait_cv(5, seen);
    chk("t2_seen0", 32'(seen), 32'd1);
    chk("t2_cw0", 32'(codeword), 32'h00);
    push(4'hF);
    push(4'h1);
    repeat (34) step();
    chk("t2_no_gap1", 32'(codeword_valid), 32'd1);
    chk("t2_cwF", 32'(codeword), 32'h7F);
    read_frame(fb);
    chk("t2_frameF", 32'(fb), 32'h1FE);
    chk("t2_no_gap2", 32'(codeword_valid), 32'd1);
    chk("t2_cw1", 32'(codeword), 32'h07);
    read_frame(fb);
    chk("t2_frame1", 32'(fb), 32'h10E);
    chk("t2_idle_after", 32'(tx_busy), 32'd0);

    // --- Test 3: overflow, 6 pushes while idle
    repeat (3) step();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      valid   = 1'b1;
      message = m3[i];
      rdy[i]  = ready;
      if (ready === 1'b1) accepted++;
      step();
    end
    valid = 1'b0;
    chk("t3_ready_pattern", 32'(rdy), 32'h1F);
    chk("t3_accepted", 32'(accepted), 32'd5);
    chk("t3_first_cw", 32'(codeword), 32'(cw_tab[3]));
    for (int f = 1; f < 5; f++) begin
      wait_cv(60, seen);
      chk("t3_seen", 32'(seen), 32'd1);
      chk("t3_order_cw", 32'(codeword), 32'(cw_tab[m3[f]]));
      read_frame(fb);
      chk("t3_frame", 32'(fb), 32'(frame_of(cw_tab[m3[f]])));
    end
    wait_cv(60, seen);
    chk("t3_no_sixth", 32'(seen), 32'd0);

    // --- Test 4: loopback through decoder model, clean and with one flipped bit
    for (int pass = 0; pass < 2; pass++) begin
      for (int m = 0; m < 16; m++) begin
        push(4'(m));
        wait_cv(5, seen);
        chk("t4_seen", 32'(seen), 32'd1);
        read_frame(fb);
        fb1 = fb;
        if (pass == 1) begin
          flip_idx      = 1 + (m % 7);
          fb1[flip_idx] = ~fb1[flip_idx];
        end
        chk("t4_framing", 32'({fb[8], fb[0]}), 32'd2);
        chk("t4_loopback", 32'(dec(fb1)), 32'(m));
      end
    end

    // --- Test 5: reset during DATA bit 3 with a queued message
    push(4'h6);
    wait_cv(5, seen);
    chk("t5_seen", 32'(seen), 32'd1);
    push(4'h9);
    repeat (16) step();
    chk("t5_data_bit3", 32'(tx_bit), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t5_tx_bit", 32'(tx_bit), 32'd1);
    chk("t5_tx_busy", 32'(tx_busy), 32'd0);
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_codeword", 32'(codeword), 32'd0);
    chk("t5_fifo_empty", 32'(u_dut.u_fifo.count_q), 32'd0);
    wait_cv(60, seen);
    chk("t5_no_frame", 32'(seen), 32'd0);
    chk("t5_line_idle", 32'(tx_bit), 32'd1);

    // --- Test 6: push on the STOP->START pop edge with one entry buffered
    push(4'hD);
    wait_cv(5, seen);
    chk("t6_seen", 32'(seen), 32'd1);
    chk("t6_cwD", 32'(codeword), 32'h66);
    push(4'h2);
    repeat (34) step();
    valid   = 1'b1;
    message = 4'h5;
    chk("t6_ready", 32'(ready), 32'd1);
    step();
    valid = 1'b0;
    chk("t6_cv", 32'(codeword_valid), 32'd1);
    chk("t6_cw2", 32'(codeword), 32'h19);
    chk("t6_count", 32'(u_dut.u_fifo.count_q), 32'd1);
    read_frame(fb);
    chk("t6_frame2", 32'(fb), 32'(frame_of(7'h19)));
    chk("t6_cv_next", 32'(codeword_valid), 32'd1);
    chk("t6_cw5", 32'(codeword), 32'h2D);
    read_frame(fb);
    chk("t6_frame5", 32'(fb), 32'(frame_of(7'h2D)));
    wait_cv(60, seen);
    chk("t6_no_more", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
